ddr2_blk_wr_sched: RTL and testbench

//  Schedules DDR2 block writes from two 64-bit requesters through the shared 64b->72b width converter.
//  - Round-robin arbitration picks one requester, which then owns the block.
//  - Issues one DDR2 block-write command, streams 64-bit words into the converter and drains 72-bit words to DDR2.
//  - Sits between the packet-side writers and the DDR2 block read/write datapath.

---
 rtl/ddr2_blk_wr_sched.sv | 140 ++++++++++++++
 tb/tb_ddr2_blk_wr_sched.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_blk_wr_sched.sv
// DDR2 block-write scheduler: round-robin over two 64-bit requesters, one command per block,
// 64b words into the width converter, 72b words out to DDR2. Optional stall abort: DDR2_BLK_WR_SCHED_TIMEOUT_EN.
module ddr2_blk_wr_sched #(
  parameter int ADDR_W    = 22,
  parameter int BLK_WORDS = 8,
  parameter int TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  output logic [1:0]        gnt,
  input  logic [63:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [1:0]        blk_done,
  output logic [63:0]       conv_wr_data,
  output logic              conv_wr_en,
  input  logic              conv_full,
  input  logic [71:0]       conv_rd_data,
  output logic              conv_rd_en,
  input  logic              conv_empty,
  output logic              conv_flush,
  output logic              cmd_valid,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_ready,
  output logic              dat_valid,
  output logic [71:0]       dat,
  input  logic              dat_ready,
  output logic              err,
  output logic [1:0]        dbg_state
);
  localparam int IN_MAX = BLK_WORDS * 9 / 8;
  localparam int IN_W   = 4 + $clog2(BLK_WORDS / 8);
  localparam int OUT_W  = $clog2(BLK_WORDS) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_XFER, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_owner, r_last_owner;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [IN_W-1:0]   r_in_cnt;
  logic [OUT_W-1:0]  r_out_cnt;
  logic              w_grant, w_grant_id, w_push, w_pop, w_abort;

  // Handshakes: a transfer happens in a cycle where valid && ready; valid never waits on ready.
  assign in_ready  = (r_state == S_CMD || r_state == S_XFER) &&
                     (r_in_cnt < IN_W'(IN_MAX)) && !conv_full;
  assign dat_valid = (r_state == S_XFER) && !conv_empty && (r_out_cnt < OUT_W'(BLK_WORDS));
  assign w_push    = in_valid && in_ready;
  assign w_pop     = dat_valid && dat_ready;

  assign w_grant    = (r_state == S_IDLE) && (|req) && !rst;
  assign w_grant_id = (req == 2'b11) ? ~r_last_owner : req[1];

  assign conv_wr_en   = w_push;
  assign conv_wr_data = in_data;
  assign conv_rd_en   = w_pop;
  assign dat          = conv_rd_data;
  assign cmd_addr     = r_cmd_addr;
  assign dbg_state    = r_state;

  always_comb begin
    w_state_nxt = r_state;
    gnt         = 2'b00;
    blk_done    = 2'b00;
    cmd_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          gnt[w_grant_id] = 1'b1;
          w_state_nxt     = S_CMD;
        end
      end
      S_CMD: begin
        cmd_valid = 1'b1;
        if (cmd_ready) w_state_nxt = S_XFER;
      end
      S_XFER: begin
        if (w_pop && r_out_cnt == OUT_W'(BLK_WORDS - 1)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        blk_done[r_owner] = 1'b1;
        w_state_nxt       = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_cmd_addr   <= '0;
      r_in_cnt     <= '0;
      r_out_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) begin
        r_in_cnt  <= '0;
        r_out_cnt <= '0;
        if (w_grant) begin
          r_owner      <= w_grant_id;
          r_last_owner <= w_grant_id;
          r_cmd_addr   <= w_grant_id ? req_addr1 : req_addr0;
        end
      end else begin
        if (w_push) r_in_cnt  <= r_in_cnt + 1'b1;
        if (w_pop)  r_out_cnt <= r_out_cnt + 1'b1;
      end
    end
  end

`ifdef DDR2_BLK_WR_SCHED_TIMEOUT_EN
  localparam int ST_W = $clog2(TIMEOUT + 1);
  logic [ST_W-1:0] r_stall;
  logic            w_busy, w_progress;

  assign w_busy     = (r_state == S_CMD) || (r_state == S_XFER);
  assign w_progress = (cmd_valid && cmd_ready) || w_push || w_pop;
  // Fires on the TIMEOUT-th consecutive cycle without progress.
  assign w_abort    = w_busy && !w_progress && (r_stall == ST_W'(TIMEOUT - 1));
  assign err        = w_abort;
  assign conv_flush = w_abort;

  always_ff @(posedge clk) begin
    if (rst || !w_busy || w_progress || w_abort) r_stall <= '0;
    else                                         r_stall <= r_stall + 1'b1;
  end
`else
  logic w_unused;
  assign w_unused   = (TIMEOUT > 0);
  assign w_abort    = 1'b0;
  assign err        = 1'b0;
  assign conv_flush = 1'b0;
`endif
endmodule

// File: tb/tb_ddr2_blk_wr_sched.sv
// Directed bench for ddr2_blk_wr_sched with a behavioural 64b->72b converter and an expected-word queue.
module tb_ddr2_blk_wr_sched;
  logic        clk, rst;
  logic [1:0]  req, gnt, blk_done, dbg_state;
  logic [21:0] req_addr0, req_addr1, cmd_addr;
  logic [63:0] in_data, conv_wr_data;
  logic        in_valid, in_ready, conv_wr_en, conv_full, conv_rd_en, conv_empty, conv_flush;
  logic [71:0] conv_rd_data, dat;
  logic        cmd_valid, cmd_ready, dat_valid, dat_ready, err;

  ddr2_blk_wr_sched #(.ADDR_W(22), .BLK_WORDS(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr0(req_addr0), .req_addr1(req_addr1), .gnt(gnt),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .blk_done(blk_done),
    .conv_wr_data(conv_wr_data), .conv_wr_en(conv_wr_en), .conv_full(conv_full),
    .conv_rd_data(conv_rd_data), .conv_rd_en(conv_rd_en), .conv_empty(conv_empty),
    .conv_flush(conv_flush), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_ready(cmd_ready),
    .dat_valid(dat_valid), .dat(dat), .dat_ready(dat_ready), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------- converter model (little-endian bit stream) ----------------
  logic [255:0] cv_buf, cv_nb;
  int           cv_cnt = 0;
  int           cv_nc;
  logic         force_full;
  assign conv_empty   = (cv_cnt < 72);
  assign conv_full    = force_full || (cv_cnt > 128);
  assign conv_rd_data = cv_buf[71:0];
  always_comb begin
    cv_nb = cv_buf;
    cv_nc = cv_cnt;
    if (conv_rd_en) begin
      cv_nb = cv_nb >> 72;
      cv_nc = cv_nc - 72;
    end
    if (conv_wr_en) begin
      cv_nb = cv_nb | ({192'd0, conv_wr_data} << cv_nc);
      cv_nc = cv_nc + 64;
    end
  end
  always @(posedge clk) begin
    if (rst || conv_flush) begin
      cv_buf <= '0;
      cv_cnt <= 0;
    end else begin
      cv_buf <= cv_nb;
      cv_cnt <= cv_nc;
    end
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0, n_errors = 0;
  logic [71:0] exp_q[$];
  logic [71:0] dat_log[$];
  logic [1:0]  gnt_q[$];
  int          gnt_cyc_q[$], done_cyc_q[$];
  logic [21:0] cmd_q[$];
  int          done_cnt = 0, beats = 0, push_cnt = 0, err_cnt = 0, err_cyc = 0, last_prog = 0;
  logic [1:0]  last_done = 2'b00;
  logic        flush_at_err = 1'b0;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (|gnt) begin gnt_q.push_back(gnt); gnt_cyc_q.push_back(cyc); end
      if (|blk_done) begin done_cnt++; last_done = blk_done; done_cyc_q.push_back(cyc); end
      if (cmd_valid && cmd_ready) cmd_q.push_back(cmd_addr);
      if (conv_wr_en) push_cnt++;
      if (conv_wr_en || conv_rd_en || (cmd_valid && cmd_ready)) last_prog = cyc;
      if (err || conv_flush) begin err_cnt++; err_cyc = cyc; flush_at_err = conv_flush; end
      if (dat_valid && dat_ready) begin
        beats++;
        dat_log.push_back(dat);
        if (exp_q.size() == 0) check_eq("dat_extra", 72'd1, 72'd0);
        else check_eq("dat", dat, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [63:0] blk_w [18];
  logic        stop_push = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 2'b00; in_valid = 1'b0; in_data = '0; force_full = 1'b0;
    cmd_ready = 1'b1; dat_ready = 1'b1; req_addr0 = '0; req_addr1 = '0;
    repeat (2) tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Fills 9 input words from seed*(i+1) and queues the 8 expected 72b words.
  task automatic fill_block(input logic [63:0] seed, input int base);
    logic [575:0] flat;
    for (int i = 0; i < 9; i++) begin
      blk_w[base + i]  = seed * 64'(i + 1);
      flat[64*i +: 64] = blk_w[base + i];
    end
    for (int k = 0; k < 8; k++) exp_q.push_back(flat[72*k +: 72]);
  endtask

  task automatic push_words(input int base, input int n);
    for (int i = 0; i < n && !stop_push; i++) begin
      int   t;
      logic ok;
      in_data = blk_w[base + i]; in_valid = 1'b1; t = 0; ok = 1'b0;
      while (!ok && t < 300 && !stop_push) begin
        @(negedge clk);
        ok = in_ready;
        tick();
        t++;
      end
      if (!ok && !stop_push) check_eq("push_timeout", 72'd0, 72'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int t = 0;
    while (done_cnt < target && t < 500) begin @(negedge clk); #1; t++; end
    if (done_cnt < target) check_eq(tag, 72'(done_cnt), 72'(target));
  endtask

  task automatic wait_gnts(input int target);
    int t = 0;
    while (gnt_q.size() < target && t < 500) begin @(negedge clk); #1; t++; end
  endtask

  task automatic grant(input logic [1:0] r, input logic [1:0] exp_g, input string tag);
    req = r;
    @(negedge clk);
    check_eq(tag, gnt, exp_g);
    tick();
    req = 2'b00;
  endtask

  function automatic logic [71:0] outs_vec();
    return 72'({gnt, blk_done, in_ready, conv_wr_en, conv_rd_en, cmd_valid, dat_valid,
                conv_flush, err, cmd_addr, dbg_state});
  endfunction

  // ---------------- tests ----------------
  int c0, b0, d0, g0, dl, p0;
  initial begin
    do_reset();
    @(negedge clk);
    check_eq("reset_outs", outs_vec(), 72'd0);
    tick();

    // 1: single block from requester 0
    fill_block(64'h1111_1111_1111_1111, 0);
    req_addr0 = 22'h12345;
    c0 = cmd_q.size(); b0 = beats; d0 = done_cnt; dl = dat_log.size();
    grant(2'b01, 2'b01, "t1_gnt");
    push_words(0, 9);
    wait_done(d0 + 1, "t1_done_timeout");
    check_eq("t1_cmd_cnt", 72'(cmd_q.size() - c0), 72'd1);
    check_eq("t1_cmd_addr", 72'(cmd_q[c0]), 72'h12345);
    check_eq("t1_beats", 72'(beats - b0), 72'd8);
    check_eq("t1_done", 72'(last_done), 72'h1);
    check_eq("t1_word0", dat_log[dl], 72'h22_1111_1111_1111_1111);
    check_eq("t1_word7", dat_log[dl + 7], 72'h9999_9999_9999_9999_88);

    // 2: both requesting, round robin across two blocks
    do_reset();
    fill_block(64'h0123_4567_89ab_cdef, 0);
    fill_block(64'hfedc_ba98_7654_3211, 9);
    req_addr0 = 22'h00aa1; req_addr1 = 22'h3bb02;
    g0 = gnt_q.size(); d0 = done_cnt; c0 = cmd_q.size(); b0 = beats;
    req = 2'b11;
    fork
      push_words(0, 18);
      begin wait_gnts(g0 + 2); tick(); req = 2'b00; end
    join
    wait_done(d0 + 2, "t2_done_timeout");
    check_eq("t2_gnt_first", 72'(gnt_q[g0]), 72'h1);
    check_eq("t2_gnt_second", 72'(gnt_q[g0 + 1]), 72'h2);
    check_eq("t2_gap", 72'(gnt_cyc_q[g0 + 1] - done_cyc_q[d0]), 72'd1);
    check_eq("t2_addr0", 72'(cmd_q[c0]), 72'h00aa1);
    check_eq("t2_addr1", 72'(cmd_q[c0 + 1]), 72'h3bb02);
    check_eq("t2_beats", 72'(beats - b0), 72'd16);
    check_eq("t2_last_done", 72'(last_done), 72'h2);

    // 3: dat_ready toggling, converter full for 3 cycles mid-block
    fill_block(64'h0f1e_2d3c_4b5a_6978, 0);
    b0 = beats; d0 = done_cnt;
    grant(2'b01, 2'b01, "t3_gnt");
    fork
      push_words(0, 9);
      begin
        for (int t = 0; t < 300 && done_cnt == d0; t++) begin dat_ready = ~dat_ready; tick(); end
        dat_ready = 1'b1;
      end
      begin
        repeat (3) tick();
        force_full = 1'b1;
        repeat (3) begin @(negedge clk); check_eq("t3_full_rdy", 72'(in_ready), 72'd0); tick(); end
        force_full = 1'b0;
      end
    join
    wait_done(d0 + 1, "t3_done_timeout");
    check_eq("t3_beats", 72'(beats - b0), 72'd8);
    check_eq("t3_exp_left", 72'(exp_q.size()), 72'd0);
    check_eq("t3_done", 72'(last_done), 72'h1);

    // 4: command stalled for 5 cycles
    fill_block(64'h5a5a_0001_a5a5_0003, 0);
    req_addr1 = 22'h2abcd; cmd_ready = 1'b0;
    b0 = beats; d0 = done_cnt; c0 = cmd_q.size(); p0 = push_cnt;
    grant(2'b10, 2'b10, "t4_gnt");
    fork
      push_words(0, 9);
      begin
        repeat (5) begin
          @(negedge clk);
          check_eq("t4_cmd_valid", 72'(cmd_valid), 72'd1);
          check_eq("t4_cmd_addr", 72'(cmd_addr), 72'h2abcd);
          check_eq("t4_no_dat", 72'(dat_valid), 72'd0);
          tick();
        end
        check_eq("t4_pushes", 72'(push_cnt - p0), 72'd3);
        cmd_ready = 1'b1;
      end
    join
    wait_done(d0 + 1, "t4_done_timeout");
    check_eq("t4_beats", 72'(beats - b0), 72'd8);
    check_eq("t4_cmd_cnt", 72'(cmd_q.size() - c0), 72'd1);
    check_eq("t4_done", 72'(last_done), 72'h2);

    // 5: reset after 4 beats, then a clean block
    fill_block(64'h3333_4444_5555_6666, 0);
    b0 = beats; d0 = done_cnt;
    grant(2'b01, 2'b01, "t5_gnt");
    fork
      push_words(0, 9);
      begin
        for (int t = 0; t < 300 && beats < b0 + 4; t++) begin @(negedge clk); #1; end
        rst = 1'b1; stop_push = 1'b1;
        tick();
        exp_q.delete();
      end
    join
    @(negedge clk);
    check_eq("t5_outs_in_rst", outs_vec(), 72'd0);
    tick();
    rst = 1'b0; stop_push = 1'b0;
    @(negedge clk);
    check_eq("t5_outs_after", outs_vec(), 72'd0);
    check_eq("t5_beats_cut", 72'(beats - b0), 72'd4);
    check_eq("t5_no_done", 72'(done_cnt - d0), 72'd0);
    tick();
    fill_block(64'h0000_00ff_ff00_0101, 0);
    req_addr1 = 22'h01357; b0 = beats; c0 = cmd_q.size();
    grant(2'b10, 2'b10, "t5_gnt_fresh");
    push_words(0, 9);
    wait_done(d0 + 1, "t5_done_timeout");
    check_eq("t5_beats", 72'(beats - b0), 72'd8);
    check_eq("t5_cmd_addr", 72'(cmd_q[c0]), 72'h01357);
    check_eq("t5_done", 72'(last_done), 72'h2);

`ifdef DDR2_BLK_WR_SCHED_TIMEOUT_EN
    // 6: output stalled forever, abort after 15 idle cycles
    do_reset();
    fill_block(64'h1234_0000_0000_4321, 0);
    dat_ready = 1'b0; d0 = done_cnt; p0 = err_cnt;
    grant(2'b01, 2'b01, "t6_gnt");
    push_words(0, 2);
    for (int t = 0; t < 100 && err_cnt == p0; t++) begin @(negedge clk); #1; end
    check_eq("t6_err_cnt", 72'(err_cnt - p0), 72'd1);
    check_eq("t6_err_delay", 72'(err_cyc - last_prog), 72'd15);
    check_eq("t6_flush", 72'(flush_at_err), 72'd1);
    @(negedge clk);
    check_eq("t6_idle", 72'(dbg_state), 72'd0);
    check_eq("t6_no_done", 72'(done_cnt - d0), 72'd0);
`else
    check_eq("no_err", 72'(err_cnt), 72'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
